// File: rtl/video_pack_ctrl.sv
// -----------------------------------------------------------------------------
// video_pack_ctrl
// Camera capture front end for the SDRAM write path. Bytes qualified by
// pix_en & href & ~vsync are packed PACK to a word, buffered in a DEPTH-word
// FIFO and emitted as fixed bursts of BURST words on a valid/ready port.
// A vsync rising edge flushes everything belonging to the previous frame.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pix_en          qualifies vsync/href/vdata sampling for capture
//   vsync, href     frame blanking (high) and line valid
//   vdata [DW]      pixel byte
//   out_data        packed word, FIFO head while out_valid
//   out_valid       out_data valid (held stable while out_ready is low)
//   out_ready       downstream accepts the word this cycle
//   burst_start     out_valid on the first word of a burst
//   frame_start     one-cycle pulse after each vsync rising edge
//   ovf / ovf_clr   sticky FIFO overflow flag and its clear
//   line_cnt        href falling edges since frame start, saturating
//   fill            FIFO word count
// -----------------------------------------------------------------------------
module video_pack_ctrl #(
  parameter int DW        = 8,
  parameter int PACK      = 2,
  parameter int DEPTH     = 512,
  parameter int BURST     = 160,
  parameter int BYTE_SWAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [DW-1:0]          vdata,
  output logic [DW*PACK-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   burst_start,
  output logic                   frame_start,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [15:0]            line_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = DW * PACK;
  localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [AW:0]   FULL_FILL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BURST_FILL = (AW+1)'(BURST);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(PACK - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(BURST - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  logic [WW-1:0] mem [DEPTH];

  logic          vsync_d_reg, href_d_reg;
  logic [SW-1:0] slot_reg;
  logic [WW-1:0] pack_reg, pack_next;
  logic          wr_req_reg;
  logic [WW-1:0] wr_data_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   fill_reg;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          out_valid_reg;
  logic [WW-1:0] out_data_reg;
  logic          frame_start_reg, ovf_reg;
  logic [15:0]   line_cnt_reg;

  logic vs_rise, capture, href_fall, full, push_ok, pop;

  assign vs_rise   = vsync & ~vsync_d_reg;
  assign capture   = pix_en & href & ~vsync;
  assign href_fall = pix_en & href_d_reg & ~href;
  // Full is judged on the registered count, i.e. before any same-cycle pop.
  assign full      = (fill_reg == FULL_FILL);
  assign push_ok   = wr_req_reg & ~full & ~vs_rise;
  assign pop       = out_valid_reg & out_ready;

  // Current word with the incoming byte dropped into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      localparam int LANE = (BYTE_SWAP != 0) ? (PACK - 1 - gi) : gi;
      assign pack_next[LANE*DW +: DW] = (capture && slot_reg == SW'(gi)) ?
                                        vdata : pack_reg[LANE*DW +: DW];
    end
  endgenerate

  // Packer, edge detectors, line counter, frame pulse and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d_reg     <= 1'b0;
      href_d_reg      <= 1'b0;
      slot_reg        <= '0;
      pack_reg        <= '0;
      wr_req_reg      <= 1'b0;
      wr_data_reg     <= '0;
      line_cnt_reg    <= '0;
      frame_start_reg <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      vsync_d_reg     <= vsync;
      frame_start_reg <= vs_rise;
      if (pix_en) href_d_reg <= href;

      // A write attempted against a full FIFO sets ovf even if a clear
      // arrives in the same cycle.
      if (wr_req_reg && full)      ovf_reg <= 1'b1;
      else if (ovf_clr || vs_rise) ovf_reg <= 1'b0;

      if (vs_rise) begin
        slot_reg     <= '0;
        pack_reg     <= '0;
        wr_req_reg   <= 1'b0;
        line_cnt_reg <= '0;
      end else begin
        wr_req_reg <= 1'b0;
        if (capture) begin
          if (slot_reg == SLOT_LAST) begin
            wr_req_reg  <= 1'b1;
            wr_data_reg <= pack_next;
            pack_reg    <= '0;
            slot_reg    <= '0;
          end else begin
            pack_reg <= pack_next;
            slot_reg <= slot_reg + SW'(1);
          end
        end else if (href_fall && slot_reg != '0) begin
          // Unfilled lanes are already zero because pack_reg clears per word.
          wr_req_reg  <= 1'b1;
          wr_data_reg <= pack_reg;
          pack_reg    <= '0;
          slot_reg    <= '0;
        end
        if (href_fall && line_cnt_reg != 16'hFFFF)
          line_cnt_reg <= line_cnt_reg + 16'd1;
      end
    end
  end

  // Storage array: write port only, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data_reg;
  end

  // FIFO pointers and burst FSM. out_data is a registered read that
  // prefetches the next head on every pop, giving first-word-fall-through.
  // Entry requires fill >= BURST, so every word read during the burst was
  // written on an earlier cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_reg      <= '0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (vs_rise) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_reg      <= '0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
        2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
        default: fill_reg <= fill_reg;
      endcase

      case (state_reg)
        ST_IDLE: begin
          if (fill_reg >= BURST_FILL) begin
            state_reg     <= ST_BURST;
            out_valid_reg <= 1'b1;
            out_data_reg  <= mem[rd_ptr_reg];
          end
        end
        ST_BURST: begin
          if (pop) begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              cnt_reg      <= cnt_reg + CW'(1);
              out_data_reg <= mem[rd_ptr_reg + AW'(1)];
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;
  assign burst_start = out_valid_reg & (cnt_reg == '0);
  assign frame_start = frame_start_reg;
  assign ovf         = ovf_reg;
  assign line_cnt    = line_cnt_reg;
  assign fill        = fill_reg;

endmodule

// File: doc/video_pack_ctrl.md
Name: video_pack_ctrl

Overview:
Single-clock, parametrised video capture front end for the SDRAM write path. It samples a byte-wide camera stream qualified by a pixel clock-enable and packs PACK bytes into one word with selectable byte order. Packed words are buffered in an internal FIFO of DEPTH words. The block then emits fixed-length bursts of BURST words on a valid/ready interface toward the SDRAM write FIFO. It adds per-frame flush, line counting and overflow reporting.

Parameters:
DW, 8, input pixel byte width
PACK, 2, bytes per output word (1..4)
DEPTH, 512, internal FIFO depth in words; power of 2, >= 2*BURST
BURST, 160, words per output burst (1..DEPTH)
BYTE_SWAP, 0, 0: first byte captured goes to LSB lane; 1: first byte goes to MSB lane

Ports:
clk  in  1  system clock; all logic is rising-edge
rst  in  1  asynchronous active-high reset
pix_en  in  1  qualifies vsync/href/vdata sample this cycle
vsync  in  1  frame sync, high = blanking
href  in  1  line valid
vdata  in  DW  pixel byte
out_data  out  DW*PACK  packed word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word
burst_start  out  1  high while first word of a burst is presented
frame_start  out  1  one-cycle pulse per frame
ovf  out  1  sticky FIFO overflow flag
ovf_clr  in  1  clears ovf
line_cnt  out  16  href falling edges since frame start, saturating
fill  out  clog2(DEPTH)+1  FIFO word count

Behaviour:
- Reset: all outputs 0; FIFO empty; packer slot 0; FSM IDLE.
- vsync rising edge, detected as vsync & ~vsync_d on any clk (not gated by pix_en):
  - frame_start pulses on the next cycle.
  - In that same cycle, FIFO pointers, fill, packer and line_cnt clear; FSM goes to IDLE; out_valid drops.
  - A partially sent burst is aborted; its remaining words are discarded.
- Capture: only on pix_en & href & ~vsync.
  - The byte goes to slot k (k = 0..PACK-1).
  - With BYTE_SWAP=0, slot k lands in lane k; with BYTE_SWAP=1, it lands in lane PACK-1-k.
  - When slot PACK-1 fills, the word is written to the FIFO on the next clk; fill reflects it one cycle later; slot returns to 0.
- Line end: href falling edge, sampled on pix_en.
  - A partial word (slot != 0) is written with the unfilled lanes zero; slot resets to 0.
  - line_cnt increments and saturates at 16'hFFFF.
- Write while full: the word is dropped and ovf sets. Full is judged before any same-cycle pop.
- ovf clears on ovf_clr or on frame flush. If set and clear occur in the same cycle, set wins.
- Simultaneous push and pop: fill is unchanged.
- Burst FSM:
  - IDLE -> BURST when fill >= BURST. out_valid rises on the next cycle with the FIFO head on out_data (first-word-fall-through).
  - In BURST, each cycle with out_valid & out_ready pops one word and increments the word counter.
  - After the BURST-th transfer, out_valid drops on the following cycle and the FSM returns to IDLE.
  - Re-entry to BURST is allowed on the cycle after returning to IDLE.
  - While out_valid & ~out_ready, out_data and out_valid are held stable.
  - burst_start = out_valid & (word counter == 0).
- Data remaining below BURST at a vsync rising edge is discarded and is not counted as overflow.
- Mid-operation rst: everything returns to reset state asynchronously, with no partial output.

Test Plan:
- PACK=2, BYTE_SWAP=0, one href of 320 bytes 0x00..0x3F repeating, pix_en every 2nd clk, out_ready=1 -> 160 words, first 16'h0100, then 16'h0302; one burst with burst_start on the first word only; line_cnt=1.
- Same stream with BYTE_SWAP=1 -> first word 16'h0001; with PACK=4 -> first word 32'h03020100.
- href of 7 bytes, PACK=2 -> 4 words written, last = {8'h00, byte6}; fill=4; no burst issued.
- out_ready held low for 10 cycles mid-burst -> out_data/out_valid stable; burst still ends after exactly 160 transfers.
- out_ready=0 with DEPTH=512 and 600 words captured -> fill=512, ovf=1; ovf_clr pulse -> ovf=0.
- vsync rises after 50 of 160 words sent -> frame_start pulse; fill=0, line_cnt=0, out_valid=0 one cycle after the edge.
